seg7_scan_driver: RTL and testbench

Parametrised multi-digit seven-segment display driver. It latches an N-digit packed BCD/hex value on a load strobe and decodes every digit to active-low segments. The decoded digits are presented two ways: a static bus for boards with one segment bus per digit, and a time-multiplexed segment/anode bus with anti-ghosting blanking for scanned displays. It sits between the datapath (counters, ALU results) and the board display pins.

---
 rtl/seg7_pkg.sv | 68 ++++++
 rtl/seg7_digit_decode.sv | 18 +
 rtl/seg7_scan_driver.sv | 136 +++++++++++++
 tb/tb_seg7_scan_driver.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg7_pkg
// Description : Seven-segment patterns (active-low, bit 0 = segment a) and the
//               code-to-pattern lookup. Define SEG7_HEX_EN to decode 10..15 as
//               A,b,C,d,E,F; otherwise those codes are blank (BCD-only).
// Revision    : 1.0  initial release
// ============================================================================
package seg7_pkg;

    typedef logic [3:0] digit_t;

    // Patterns are {g,f,e,d,c,b,a}; 0 = segment lit.
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    function automatic logic [6:0] seg7_pattern(input digit_t code);
        logic [6:0] pattern;
        case (code)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10:   pattern = SEG_A;
            4'd11:   pattern = SEG_B;
            4'd12:   pattern = SEG_C;
            4'd13:   pattern = SEG_D;
            4'd14:   pattern = SEG_E;
            4'd15:   pattern = SEG_F;
`endif
            default: pattern = SEG_BLANK;
        endcase
        return pattern;
    endfunction

    // A code that renders blank must not light its decimal point either.
    function automatic logic seg7_code_shown(input digit_t code);
`ifdef SEG7_HEX_EN
        return (code == code);
`else
        return (code < 4'd10);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_digit_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_digit_decode
// Description : Combinational single-digit decoder, code + blank -> segments.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_digit_decode
    import seg7_pkg::*;
(
    input  digit_t     code,
    input  logic       blank,
    output logic [6:0] seg
);

    assign seg = blank ? SEG_BLANK : seg7_pattern(code);

endmodule
`default_nettype wire

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : seg7_scan_driver
// Description : N-digit seven-segment driver with static and scanned outputs,
//               leading-zero blanking and anti-ghost slot blanking.
//               Build option SEG7_HEX_EN enables A..F decode of codes 10..15.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS  = 4,
    parameter int SCAN_DIV  = 50000,
    parameter int GHOST_CYC = 2
)
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*N_DIGITS-1:0] value_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic                  lz_blank,
    output logic [7*N_DIGITS-1:0] hex_out,
    output logic [6:0]            seg_out,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an_out
);

    localparam int c_IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int c_PRE_W = $clog2(SCAN_DIV);

    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(SCAN_DIV - 1);
    localparam logic [c_PRE_W-1:0] c_GHOST_END = c_PRE_W'(GHOST_CYC);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST  = c_IDX_W'(N_DIGITS - 1);

    logic [4*N_DIGITS-1:0] r_value;
    logic [N_DIGITS-1:0]   r_dp;
    logic [7*N_DIGITS-1:0] r_hex;
    logic [6:0]            r_seg;
    logic                  r_dp_out;
    logic [N_DIGITS-1:0]   r_an;
    logic [c_PRE_W-1:0]    r_presc;
    logic [c_IDX_W-1:0]    r_idx;

    logic [N_DIGITS-1:0]   w_blank;
    logic                  w_zero_run;
    logic [7*N_DIGITS-1:0] w_seg;
    logic [N_DIGITS-1:0]   w_dp_lit;
    logic                  w_presc_tc;
    logic [c_PRE_W-1:0]    w_presc_nxt;
    logic [c_IDX_W-1:0]    w_idx_nxt;
    logic [N_DIGITS-1:0]   w_an_nxt;
    logic [6:0]            w_seg_sel;
    logic                  w_dp_sel;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_value <= '0;
            r_dp    <= '0;
        end else if (load) begin
            r_value <= value_in;
            r_dp    <= dp_in;
        end
    end

    // Zero run from the most significant digit down; digit 0 always shows.
    always_comb begin
        w_blank    = '0;
        w_zero_run = lz_blank;
        for (int k = N_DIGITS - 1; k >= 1; k--) begin
            w_zero_run = w_zero_run & (r_value[4*k +: 4] == 4'd0);
            w_blank[k] = w_zero_run;
        end
    end

    for (genvar k = 0; k < N_DIGITS; k++) begin : g_digit
        seg7_digit_decode u_decode (
            .code  (r_value[4*k +: 4]),
            .blank (w_blank[k]),
            .seg   (w_seg[7*k +: 7])
        );
        assign w_dp_lit[k] = r_dp[k] & ~w_blank[k] & seg7_code_shown(r_value[4*k +: 4]);
    end

    assign w_presc_tc  = (r_presc == c_PRE_LAST);
    assign w_presc_nxt = w_presc_tc ? '0 : r_presc + 1'b1;

    always_comb begin
        w_idx_nxt = r_idx;
        if (w_presc_tc) begin
            w_idx_nxt = (r_idx == c_IDX_LAST) ? '0 : r_idx + 1'b1;
        end
    end

    // Scan outputs are registered from the next scan position so that the
    // visible anode pattern tracks the prescaler/index registers exactly.
    always_comb begin
        w_an_nxt  = '1;
        w_seg_sel = SEG_BLANK;
        w_dp_sel  = 1'b1;
        for (int k = 0; k < N_DIGITS; k++) begin
            if (w_idx_nxt == c_IDX_W'(k)) begin
                w_seg_sel = w_seg[7*k +: 7];
                w_dp_sel  = ~w_dp_lit[k];
                if (w_presc_nxt >= c_GHOST_END) begin
                    w_an_nxt[k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hex    <= '1;
            r_seg    <= SEG_BLANK;
            r_dp_out <= 1'b1;
            r_an     <= '1;
            r_presc  <= '0;
            r_idx    <= '0;
        end else begin
            r_hex    <= w_seg;
            r_seg    <= w_seg_sel;
            r_dp_out <= w_dp_sel;
            r_an     <= w_an_nxt;
            r_presc  <= w_presc_nxt;
            r_idx    <= w_idx_nxt;
        end
    end

    assign hex_out = r_hex;
    assign seg_out = r_seg;
    assign dp_out  = r_dp_out;
    assign an_out  = r_an;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg7_scan_driver
// Description : Self-checking bench for seg7_scan_driver (4 digits, 8-cycle
//               slots, 2 ghost cycles) against a behavioural display model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_seg7_scan_driver;

    localparam int N  = 4;
    localparam int SD = 8;
    localparam int GH = 2;

`ifdef SEG7_HEX_EN
    localparam bit HEX = 1'b1;
`else
    localparam bit HEX = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          load;
    logic [15:0]   value_in;
    logic [3:0]    dp_in;
    logic          lz_blank;
    logic [27:0]   hex_out;
    logic [6:0]    seg_out;
    logic          dp_out;
    logic [3:0]    an_out;

    seg7_scan_driver #(
        .N_DIGITS  (N),
        .SCAN_DIV  (SD),
        .GHOST_CYC (GH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .value_in (value_in),
        .dp_in    (dp_in),
        .lz_blank (lz_blank),
        .hex_out  (hex_out),
        .seg_out  (seg_out),
        .dp_out   (dp_out),
        .an_out   (an_out)
    );

    always #5 clk = ~clk;

    // Segment strings in a..g order, '0' = lit.
    string c_pat [16] = '{"0000001", "1001111", "0010010", "0000110",
                          "1001100", "0100100", "0100000", "0001111",
                          "0000000", "0000100", "0001000", "1100000",
                          "0110001", "1000010", "0110000", "0111000"};

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [27:0] m_hex;
    logic [3:0]  m_dpo;
    int          m_edges;

    function automatic logic [6:0] pat(input string s);
        logic [6:0] p;
        for (int i = 0; i < 7; i++) p[i] = (s[i] == "1");
        return p;
    endfunction

    function automatic bit model_blank(input logic [15:0] v, input logic lz, input int k);
        return lz && (k > 0) && ((v >> (4 * k)) == 16'd0);
    endfunction

    function automatic logic [6:0] model_seg(input logic [15:0] v, input logic lz, input int k);
        int nib;
        nib = int'((v >> (4 * k)) & 16'hF);
        if (model_blank(v, lz, k) || (!HEX && nib > 9)) return pat("1111111");
        return pat(c_pat[nib]);
    endfunction

    function automatic logic model_dp(input logic [15:0] v, input logic [3:0] d,
                                      input logic lz, input int k);
        int nib;
        nib = int'((v >> (4 * k)) & 16'hF);
        return !(d[k] && !model_blank(v, lz, k) && (HEX || nib < 10));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock edge: update the model from pre-edge state, then compare all outputs.
    task automatic cyc();
        logic [27:0] nh;
        logic [3:0]  nd;
        logic [3:0]  an_exp;
        int p, ix;
        @(posedge clk);
        for (int k = 0; k < N; k++) begin
            nh[7*k +: 7] = model_seg(m_val, lz_blank, k);
            nd[k]        = model_dp(m_val, m_dp, lz_blank, k);
        end
        m_hex = nh;
        m_dpo = nd;
        if (load) begin
            m_val = value_in;
            m_dp  = dp_in;
        end
        m_edges++;
        #1;
        p  = m_edges % SD;
        ix = (m_edges / SD) % N;
        an_exp = 4'hF;
        if (p >= GH) an_exp[ix] = 1'b0;
        check("hex_out", hex_out, m_hex);
        check("an_out", an_out, an_exp);
        check("seg_out", seg_out, m_hex[7*ix +: 7]);
        check("dp_out", dp_out, m_dpo[ix]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_slot(input int idx, input int pos);
        for (int i = 0; i < 4 * N * SD && !((m_edges % SD) == pos && ((m_edges / SD) % N) == idx); i++)
            cyc();
        check("wait_slot", (m_edges % SD == pos) && ((m_edges / SD) % N == idx), 1);
    endtask

    task automatic model_reset();
        m_val   = '0;
        m_dp    = '0;
        m_hex   = '1;
        m_dpo   = '1;
        m_edges = 0;
    endtask

    task automatic load_once(input logic [15:0] v, input logic [3:0] d);
        load     = 1'b1;
        value_in = v;
        dp_in    = d;
        cyc();
        load     = 1'b0;
    endtask

    initial begin
        logic [15:0] mask;
        rst      = 1'b1;
        load     = 1'b0;
        value_in = '0;
        dp_in    = '0;
        lz_blank = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst_hex", hex_out, 28'hFFFFFFF);
        check("rst_an", an_out, 4'hF);
        check("rst_seg", seg_out, 7'h7F);
        check("rst_dp", dp_out, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        run(3);

        // Basic decode of 1234, then two full scan periods.
        load_once(16'h1234, 4'b0000);
        cyc();
        check("d0_4", hex_out[6:0],   pat("1001100"));
        check("d1_3", hex_out[13:7],  pat("0000110"));
        check("d2_2", hex_out[20:14], pat("0010010"));
        check("d3_1", hex_out[27:21], pat("1001111"));
        run(2 * N * SD);

        // Asynchronous reset in the middle of a lit slot.
        wait_slot(2, 4);
        rst = 1'b1;
        #2;
        check("arst_an", an_out, 4'hF);
        check("arst_seg", seg_out, 7'h7F);
        check("arst_dp", dp_out, 1'b1);
        check("arst_hex", hex_out, 28'hFFFFFFF);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        run(2);

        // Leading-zero blanking.
        lz_blank = 1'b1;
        load_once(16'h0040, 4'b0000);
        cyc();
        check("lz_d3", hex_out[27:21], pat("1111111"));
        check("lz_d2", hex_out[20:14], pat("1111111"));
        check("lz_d1", hex_out[13:7],  pat("1001100"));
        check("lz_d0", hex_out[6:0],   pat("0000001"));
        load_once(16'h0000, 4'b1000);
        cyc();
        check("zero_hex", hex_out, {pat("1111111"), pat("1111111"), pat("1111111"), pat("0000001")});
        wait_slot(3, 4);
        check("blank_dp", dp_out, 1'b1);
        check("blank_an", an_out, 4'b0111);
        run(SD);

        // Codes above 9: hex letters or blank depending on build.
        lz_blank = 1'b0;
        load_once(16'hABCF, 4'b1111);
        cyc();
        check("abcf_d3", hex_out[27:21], HEX ? pat("0001000") : pat("1111111"));
        check("abcf_d2", hex_out[20:14], HEX ? pat("1100000") : pat("1111111"));
        check("abcf_d1", hex_out[13:7],  HEX ? pat("0110001") : pat("1111111"));
        check("abcf_d0", hex_out[6:0],   HEX ? pat("0111000") : pat("1111111"));
        run(N * SD);

        // Load while digit 0 is lit: new pattern exactly two edges after the strobe.
        load_once(16'h0000, 4'b0000);
        wait_slot(0, 3);
        load_once(16'h0009, 4'b0000);
        check("mid_seg_e1", seg_out, pat("0000001"));
        cyc();
        check("mid_seg_e2", seg_out, pat("0000100"));
        check("mid_an", an_out, 4'b1110);
        run(SD);

        // Load held high: shadow follows value_in every cycle.
        load = 1'b1;
        for (int i = 0; i < 12; i++) begin
            value_in = 16'($urandom);
            dp_in    = 4'($urandom);
            cyc();
        end
        load = 1'b0;

        // Randomised traffic, including loads that coincide with slot wraps.
        for (int i = 0; i < 300; i++) begin
            mask     = 16'hFFFF >> (4 * $urandom_range(0, 4));
            load     = ($urandom_range(0, 3) == 0);
            value_in = 16'($urandom) & mask;
            dp_in    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) lz_blank = ~lz_blank;
            cyc();
        end
        load = 1'b0;
        run(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "bench timeout");
    end

endmodule
`default_nettype wire
